// File: rtl/spi_flash_responder.sv
// Single-bit SPI flash device model: oversamples the SPI pins with clk, decodes READ,
// and streams bytes MSB-first from an internal loadable byte memory.
module spi_flash_responder #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter logic [7:0]  READ_CMD  = 8'h03
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flash_csb,
    input  logic                         flash_clk,
    input  logic                         flash_io0_di,
    output logic                         flash_io1_do,
    output logic                         flash_io1_oe,
    input  logic                         load_valid,
    input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
    input  logic [7:0]                   load_data,
    output logic                         active
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } state_t;

    state_t          state;
    logic            csb_meta, csb_sync;
    logic            sclk_meta, sclk_sync, sclk_prev;
    logic            mosi_meta, mosi_sync;
    logic            sclk_rise, sclk_fall;
    logic [6:0]      op_sr;
    logic [AW-2:0]   addr_sr;
    logic [AW-1:0]   addr_full;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   rd_next;
    logic [4:0]      bit_cnt;
    logic [2:0]      data_cnt;
    logic [7:0]      data_sr;
    logic [7:0]      mem [MEM_BYTES];

    // Two-flop synchronizers plus one history flop for SPI clock edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb_meta  <= 1'b1;
            csb_sync  <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            csb_meta  <= flash_csb;
            csb_sync  <= csb_meta;
            sclk_meta <= flash_clk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            mosi_meta <= flash_io0_di;
            mosi_sync <= mosi_meta;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;

    // Only the low AW address bits are kept, which gives the modulo-depth mapping for free
    assign addr_full = {addr_sr, mosi_sync};
    assign rd_next   = rd_addr + AW'(1);

    // Memory keeps its contents across rst; reads below see the pre-write value
    always_ff @(posedge clk) begin
        if (load_valid) begin
            mem[load_addr] <= load_data;
        end
    end

    // Transaction FSM; csb high takes priority over any edge seen in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op_sr        <= '0;
            addr_sr      <= '0;
            rd_addr      <= '0;
            bit_cnt      <= '0;
            data_cnt     <= '0;
            data_sr      <= '0;
            flash_io1_do <= 1'b0;
            flash_io1_oe <= 1'b0;
            active       <= 1'b0;
        end else if (csb_sync) begin
            state        <= IDLE;
            op_sr        <= '0;
            addr_sr      <= '0;
            bit_cnt      <= '0;
            data_cnt     <= '0;
            flash_io1_oe <= 1'b0;
            active       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= CMD;
                    bit_cnt <= '0;
                    active  <= 1'b1;
                end
                CMD: begin
                    if (sclk_rise) begin
                        op_sr <= 7'({op_sr, mosi_sync});
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            state   <= ({op_sr, mosi_sync} == READ_CMD) ? ADDR : IGNORE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        addr_sr <= (AW-1)'(addr_full);
                        if (bit_cnt == 5'd23) begin
                            bit_cnt  <= '0;
                            rd_addr  <= addr_full;
                            data_sr  <= mem[addr_full];
                            data_cnt <= '0;
                            state    <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        flash_io1_oe <= 1'b1;
                        flash_io1_do <= data_sr[7];
                        data_sr      <= {data_sr[6:0], 1'b0};
                        data_cnt     <= data_cnt + 3'd1;
                    end else if (sclk_rise && (data_cnt == 3'd0)) begin
                        // Byte fully emitted: prefetch the next one between fall pulses
                        rd_addr <= rd_next;
                        data_sr <= mem[rd_next];
                    end
                end
                IGNORE: begin
                    state <= IGNORE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
